// File: rtl/ptp_pkg.sv
// rtl/ptp_pkg.sv - shared constants, entry layout and FSM encoding for the timestamp unit
package ptp_pkg;

  localparam logic [2:0] REG_CTRL        = 3'd0;
  localparam logic [2:0] REG_STATUS      = 3'd1;
  localparam logic [2:0] REG_HEAD_INFOR  = 3'd2;
  localparam logic [2:0] REG_HEAD_SEC_HI = 3'd3;
  localparam logic [2:0] REG_HEAD_SEC_LO = 3'd4;
  localparam logic [2:0] REG_HEAD_NS     = 3'd5;

  // Entry layout: {infor[111:80], sec[79:32], ns[31:0]}
  localparam int ENTRY_W   = 112;
  localparam int NS_LSB    = 0;
  localparam int SEC_LSB   = 32;
  localparam int INFOR_LSB = 80;

  localparam logic [7:0] MASK_RST_DEF = 8'h0F;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FRAME  = 2'd1,
    ST_RESULT = 2'd2
  } state_e;

endpackage

// File: rtl/ptp_ts_fifo.sv
// rtl/ptp_ts_fifo.sv - show-ahead synchronous FIFO holding matched timestamp entries
module ptp_ts_fifo
  import ptp_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               push_i,
  input  logic               pop_i,
  input  logic [ENTRY_W-1:0] din_i,
  output logic [ENTRY_W-1:0] dout_o,
  output logic [AW:0]        level_o,
  output logic               full_o,
  output logic               empty_o
);

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]      wptr_q, rptr_q;
  logic [AW:0]        level_q;
  logic               do_push, do_pop;

  assign full_o  = (level_q == (AW+1)'(DEPTH));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign dout_o  = mem_q[rptr_q];

  // A pop in the same cycle frees the slot, so a push while full still lands.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wptr_q] <= din_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: rtl/ptp_tsu_ctrl.sv
// rtl/ptp_tsu_ctrl.sv - captures RTC at SOP, pairs it with the parser result and queues PTP events
module ptp_tsu_ctrl
  import ptp_pkg::*;
#(
  parameter int         DEPTH    = 8,
  parameter int         AW       = 3,
  parameter logic [7:0] MASK_RST = MASK_RST_DEF
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        int_valid_i,
  input  logic        int_sop_i,
  input  logic        int_eop_i,
  input  logic [47:0] rtc_sec_i,
  input  logic [31:0] rtc_ns_i,
  input  logic        ptp_found_i,
  input  logic [31:0] ptp_infor_i,
  output logic [7:0]  ptp_msgid_mask_o,
  input  logic [2:0]  reg_addr_i,
  input  logic        reg_wr_i,
  input  logic [31:0] reg_wdata_i,
  input  logic        reg_rd_i,
  output logic [31:0] reg_rdata_o,
  output logic        reg_rvalid_o,
  output logic        irq_o
);

  state_e             state_q;
  logic [47:0]        pend_sec_q;
  logic [31:0]        pend_ns_q;
  logic               enable_q;
  logic [7:0]         mask_q;
  logic [15:0]        drop_q;
  logic [31:0]        rdata_q;
  logic               rvalid_q;

  logic               sop_w, eop_w, start_w;
  logic               push_w, pop_w, drop_w, clr_w;
  logic [ENTRY_W-1:0] din_w, dout_w;
  logic [AW:0]        level_w;
  logic               full_w, empty_w;
  logic [31:0]        rd_mux;

  assign sop_w   = int_valid_i && int_sop_i;
  assign eop_w   = int_valid_i && int_eop_i;
  assign start_w = sop_w && enable_q;

  assign push_w = (state_q == ST_RESULT) && ptp_found_i;
  assign din_w  = {ptp_infor_i, pend_sec_q, pend_ns_q};
  assign pop_w  = reg_rd_i && (reg_addr_i == REG_HEAD_NS) && !empty_w;
  assign drop_w = push_w && full_w && !pop_w;
  assign clr_w  = reg_wr_i && (reg_addr_i == REG_CTRL) && reg_wdata_i[1];

  ptp_ts_fifo #(.DEPTH(DEPTH), .AW(AW)) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push_w),
    .pop_i   (pop_w),
    .din_i   (din_w),
    .dout_o  (dout_w),
    .level_o (level_w),
    .full_o  (full_w),
    .empty_o (empty_w)
  );

  // A fresh SOP always re-latches, so back-to-back frames start from the RESULT cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      pend_sec_q <= '0;
      pend_ns_q  <= '0;
    end else begin
      if (start_w) begin
        pend_sec_q <= rtc_sec_i;
        pend_ns_q  <= rtc_ns_i;
        state_q    <= eop_w ? ST_RESULT : ST_FRAME;
      end else if (state_q == ST_FRAME) begin
        if (sop_w)      state_q <= ST_IDLE;
        else if (eop_w) state_q <= ST_RESULT;
      end else begin
        state_q <= ST_IDLE;
      end
    end
  end

  always_comb begin
    rd_mux = '0;
    case (reg_addr_i)
      REG_CTRL:        rd_mux = {16'h0, mask_q, 7'h0, enable_q};
      REG_STATUS:      rd_mux = {drop_q, 6'h0, full_w, empty_w, 8'(level_w)};
      REG_HEAD_INFOR:  if (!empty_w) rd_mux = dout_w[INFOR_LSB +: 32];
      REG_HEAD_SEC_HI: if (!empty_w) rd_mux = {16'h0, dout_w[SEC_LSB+32 +: 16]};
      REG_HEAD_SEC_LO: if (!empty_w) rd_mux = dout_w[SEC_LSB +: 32];
      REG_HEAD_NS:     if (!empty_w) rd_mux = dout_w[NS_LSB +: 32];
      default:         rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      enable_q <= 1'b0;
      mask_q   <= MASK_RST;
      drop_q   <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      if (reg_wr_i && (reg_addr_i == REG_CTRL)) begin
        enable_q <= reg_wdata_i[0];
        mask_q   <= reg_wdata_i[15:8];
      end
      if (clr_w) begin
        drop_q <= '0;
      end else if (drop_w && (drop_q != 16'hFFFF)) begin
        drop_q <= drop_q + 16'd1;
      end
      rvalid_q <= reg_rd_i;
      if (reg_rd_i) rdata_q <= rd_mux;
    end
  end

  assign ptp_msgid_mask_o = mask_q;
  assign reg_rdata_o      = rdata_q;
  assign reg_rvalid_o     = rvalid_q;
  assign irq_o            = enable_q && !empty_w;

endmodule

// File: tb/tb_ptp_tsu_ctrl.sv
// tb/tb_ptp_tsu_ctrl.sv - directed self-checking bench for ptp_tsu_ctrl
module tb_ptp_tsu_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        int_valid, int_sop, int_eop;
  logic [47:0] rtc_sec;
  logic [31:0] rtc_ns;
  logic        ptp_found;
  logic [31:0] ptp_infor;
  logic [7:0]  mask;
  logic [2:0]  reg_addr;
  logic        reg_wr, reg_rd;
  logic [31:0] reg_wdata, reg_rdata;
  logic        reg_rvalid, irq;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ptp_tsu_ctrl #(.DEPTH(8), .AW(3), .MASK_RST(8'h0F)) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .int_valid_i      (int_valid),
    .int_sop_i        (int_sop),
    .int_eop_i        (int_eop),
    .rtc_sec_i        (rtc_sec),
    .rtc_ns_i         (rtc_ns),
    .ptp_found_i      (ptp_found),
    .ptp_infor_i      (ptp_infor),
    .ptp_msgid_mask_o (mask),
    .reg_addr_i       (reg_addr),
    .reg_wr_i         (reg_wr),
    .reg_wdata_i      (reg_wdata),
    .reg_rd_i         (reg_rd),
    .reg_rdata_o      (reg_rdata),
    .reg_rvalid_o     (reg_rvalid),
    .irq_o            (irq)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reg_write(input logic [2:0] a, input logic [31:0] d);
    reg_addr = a; reg_wdata = d; reg_wr = 1'b1;
    tick();
    reg_wr = 1'b0;
  endtask

  task automatic reg_read(input logic [2:0] a, output logic [31:0] d, output logic v);
    reg_addr = a; reg_rd = 1'b1;
    tick();
    reg_rd = 1'b0;
    d = reg_rdata; v = reg_rvalid;
  endtask

  // rtc moves after SOP so a late latch would be visible
  task automatic send_frame(input logic [47:0] sec, input logic [31:0] ns, input int len,
                            input logic found, input logic [31:0] infor);
    int_valid = 1'b1; int_sop = 1'b1; int_eop = (len == 1); rtc_sec = sec; rtc_ns = ns;
    tick();
    int_sop = 1'b0; rtc_sec = sec + 48'd7; rtc_ns = ns + 32'h100;
    for (int i = 1; i < len; i++) begin
      int_eop = (i == len - 1);
      tick();
    end
    int_valid = 1'b0; int_eop = 1'b0; ptp_found = found; ptp_infor = infor;
    tick();
    ptp_found = 1'b0; ptp_infor = '0;
  endtask

  task automatic test_reset();
    logic [31:0] d; logic v;
    rst = 1'b1;
    tick(); tick();
    n_cmp++; if (mask !== 8'h0F) begin n_bad++; $display("FAIL reset_mask got=%h exp=0f", mask); end
    n_cmp++; if (reg_rdata !== 32'h0) begin n_bad++; $display("FAIL reset_rdata got=%h exp=0", reg_rdata); end
    n_cmp++; if (reg_rvalid !== 1'b0) begin n_bad++; $display("FAIL reset_rvalid got=%b exp=0", reg_rvalid); end
    n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL reset_irq got=%b exp=0", irq); end
    rst = 1'b0;
    reg_read(3'd1, d, v);
    n_cmp++; if (d !== 32'h0000_0100 || v !== 1'b1) begin n_bad++; $display("FAIL reset_status got=%h/%b exp=00000100/1", d, v); end
    reg_read(3'd0, d, v);
    n_cmp++; if (d !== 32'h0000_0F00) begin n_bad++; $display("FAIL reset_ctrl got=%h exp=00000f00", d); end
    tick();
    n_cmp++; if (reg_rvalid !== 1'b0) begin n_bad++; $display("FAIL rvalid_pulse got=%b exp=0", reg_rvalid); end
  endtask

  task automatic test_basic();
    logic [31:0] d; logic v;
    reg_write(3'd0, 32'h0000_0F01);
    send_frame(48'h0000_0000_0010, 32'h0000_1000, 3, 1'b1, 32'h1ABC_0042);
    n_cmp++; if (irq !== 1'b1) begin n_bad++; $display("FAIL basic_irq_up got=%b exp=1", irq); end
    reg_read(3'd1, d, v);
    n_cmp++; if (d !== 32'h0000_0001) begin n_bad++; $display("FAIL basic_status got=%h exp=00000001", d); end
    reg_read(3'd2, d, v);
    n_cmp++; if (d !== 32'h1ABC_0042) begin n_bad++; $display("FAIL basic_infor got=%h exp=1abc0042", d); end
    reg_read(3'd3, d, v);
    n_cmp++; if (d !== 32'h0000_0000) begin n_bad++; $display("FAIL basic_sec_hi got=%h exp=0", d); end
    reg_read(3'd4, d, v);
    n_cmp++; if (d !== 32'h0000_0010) begin n_bad++; $display("FAIL basic_sec_lo got=%h exp=10", d); end
    reg_read(3'd5, d, v);
    n_cmp++; if (d !== 32'h0000_1000) begin n_bad++; $display("FAIL basic_ns got=%h exp=1000", d); end
    reg_read(3'd1, d, v);
    n_cmp++; if (d !== 32'h0000_0100) begin n_bad++; $display("FAIL basic_after_pop got=%h exp=00000100", d); end
    n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL basic_irq_down got=%b exp=0", irq); end
  endtask

  task automatic test_non_ptp();
    logic [31:0] d; logic v;
    send_frame(48'h20, 32'h2, 2, 1'b0, 32'h5555_5555);
    reg_read(3'd1, d, v);
    n_cmp++; if (d !== 32'h0000_0100) begin n_bad++; $display("FAIL nonptp_status got=%h exp=00000100", d); end
    n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL nonptp_irq got=%b exp=0", irq); end
    reg_write(3'd0, 32'h0000_0F00);
    send_frame(48'h21, 32'h3, 2, 1'b1, 32'h6666_6666);
    reg_read(3'd1, d, v);
    n_cmp++; if (d !== 32'h0000_0100) begin n_bad++; $display("FAIL disabled_status got=%h exp=00000100", d); end
    reg_write(3'd0, 32'h0000_0F01);
  endtask

  task automatic test_overflow();
    logic [31:0] d; logic v;
    for (int i = 0; i < 11; i++)
      send_frame(48'(i), 32'h2000 + 32'(i), 2, 1'b1, 32'h3000_0000 + 32'(i));
    reg_read(3'd1, d, v);
    n_cmp++; if (d !== 32'h0003_0208) begin n_bad++; $display("FAIL ovf_status got=%h exp=00030208", d); end
    reg_write(3'd0, 32'h0000_0F03);
    reg_read(3'd1, d, v);
    n_cmp++; if (d !== 32'h0000_0208) begin n_bad++; $display("FAIL ovf_drop_clr got=%h exp=00000208", d); end
    reg_read(3'd0, d, v);
    n_cmp++; if (d !== 32'h0000_0F01) begin n_bad++; $display("FAIL ovf_ctrl_selfclr got=%h exp=00000f01", d); end
    int_valid = 1'b1; int_sop = 1'b1; rtc_sec = 48'h99; rtc_ns = 32'h2099;
    tick();
    int_sop = 1'b0; int_eop = 1'b1;
    tick();
    int_valid = 1'b0; int_eop = 1'b0; ptp_found = 1'b1; ptp_infor = 32'h3000_0099;
    reg_addr = 3'd5; reg_rd = 1'b1;
    tick();
    reg_rd = 1'b0; ptp_found = 1'b0;
    n_cmp++; if (reg_rdata !== 32'h0000_2000) begin n_bad++; $display("FAIL ovf_pop_push_data got=%h exp=2000", reg_rdata); end
    reg_read(3'd1, d, v);
    n_cmp++; if (d !== 32'h0000_0208) begin n_bad++; $display("FAIL ovf_pop_push_level got=%h exp=00000208", d); end
    for (int k = 0; k < 8; k++) begin
      reg_read(3'd5, d, v);
      n_cmp++;
      if (d !== ((k < 7) ? 32'h2001 + 32'(k) : 32'h2099)) begin
        n_bad++; $display("FAIL ovf_drain_%0d got=%h exp=%h", k, d, (k < 7) ? 32'h2001 + 32'(k) : 32'h2099);
      end
    end
    reg_read(3'd1, d, v);
    n_cmp++; if (d !== 32'h0000_0100) begin n_bad++; $display("FAIL ovf_drained got=%h exp=00000100", d); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d; logic v;
    int_valid = 1'b1; int_sop = 1'b1; rtc_sec = 48'h40; rtc_ns = 32'h4000;
    tick();
    int_sop = 1'b0; int_eop = 1'b1; rtc_sec = 48'h41; rtc_ns = 32'h4100;
    tick();
    int_sop = 1'b1; int_eop = 1'b0; rtc_sec = 48'h50; rtc_ns = 32'h5000;
    ptp_found = 1'b1; ptp_infor = 32'h0000_000A;
    tick();
    ptp_found = 1'b0; int_sop = 1'b0; int_eop = 1'b1; rtc_sec = 48'h51; rtc_ns = 32'h5100;
    tick();
    int_valid = 1'b0; int_eop = 1'b0; ptp_found = 1'b1; ptp_infor = 32'h0000_000B;
    tick();
    ptp_found = 1'b0;
    reg_read(3'd1, d, v);
    n_cmp++; if (d !== 32'h0000_0002) begin n_bad++; $display("FAIL b2b_status got=%h exp=00000002", d); end
    reg_read(3'd2, d, v);
    n_cmp++; if (d !== 32'h0000_000A) begin n_bad++; $display("FAIL b2b_a_infor got=%h exp=a", d); end
    reg_read(3'd4, d, v);
    n_cmp++; if (d !== 32'h0000_0040) begin n_bad++; $display("FAIL b2b_a_sec got=%h exp=40", d); end
    reg_read(3'd5, d, v);
    n_cmp++; if (d !== 32'h0000_4000) begin n_bad++; $display("FAIL b2b_a_ns got=%h exp=4000", d); end
    reg_read(3'd2, d, v);
    n_cmp++; if (d !== 32'h0000_000B) begin n_bad++; $display("FAIL b2b_b_infor got=%h exp=b", d); end
    reg_read(3'd4, d, v);
    n_cmp++; if (d !== 32'h0000_0050) begin n_bad++; $display("FAIL b2b_b_sec got=%h exp=50", d); end
    reg_read(3'd5, d, v);
    n_cmp++; if (d !== 32'h0000_5000) begin n_bad++; $display("FAIL b2b_b_ns got=%h exp=5000", d); end
  endtask

  task automatic test_config_reset();
    logic [31:0] d; logic v;
    reg_write(3'd0, 32'h0000_0301);
    n_cmp++; if (mask !== 8'h03) begin n_bad++; $display("FAIL cfg_mask got=%h exp=03", mask); end
    int_valid = 1'b1; int_sop = 1'b1; rtc_sec = 48'h77; rtc_ns = 32'h7777;
    tick();
    int_sop = 1'b0;
    tick();
    int_valid = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++; if (mask !== 8'h0F) begin n_bad++; $display("FAIL rst_mask got=%h exp=0f", mask); end
    reg_write(3'd0, 32'h0000_0F01);
    int_valid = 1'b1; int_eop = 1'b1;
    tick();
    int_valid = 1'b0; int_eop = 1'b0; ptp_found = 1'b1; ptp_infor = 32'h7777_7777;
    tick();
    ptp_found = 1'b0;
    reg_read(3'd1, d, v);
    n_cmp++; if (d !== 32'h0000_0100) begin n_bad++; $display("FAIL rst_no_entry got=%h exp=00000100", d); end
    n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL rst_irq got=%b exp=0", irq); end
  endtask

  task automatic test_empty_sop_eop();
    logic [31:0] d; logic v;
    reg_read(3'd5, d, v);
    n_cmp++; if (d !== 32'h0 || v !== 1'b1) begin n_bad++; $display("FAIL empty_read got=%h/%b exp=0/1", d, v); end
    reg_read(3'd1, d, v);
    n_cmp++; if (d !== 32'h0000_0100) begin n_bad++; $display("FAIL empty_level got=%h exp=00000100", d); end
    send_frame(48'h1234_5678_9ABC, 32'h0BAD_F00D, 1, 1'b1, 32'h2222_0007);
    reg_read(3'd1, d, v);
    n_cmp++; if (d !== 32'h0000_0001) begin n_bad++; $display("FAIL single_status got=%h exp=00000001", d); end
    reg_read(3'd2, d, v);
    n_cmp++; if (d !== 32'h2222_0007) begin n_bad++; $display("FAIL single_infor got=%h exp=22220007", d); end
    reg_read(3'd3, d, v);
    n_cmp++; if (d !== 32'h0000_1234) begin n_bad++; $display("FAIL single_sec_hi got=%h exp=1234", d); end
    reg_read(3'd4, d, v);
    n_cmp++; if (d !== 32'h5678_9ABC) begin n_bad++; $display("FAIL single_sec_lo got=%h exp=56789abc", d); end
    reg_read(3'd5, d, v);
    n_cmp++; if (d !== 32'h0BAD_F00D) begin n_bad++; $display("FAIL single_ns got=%h exp=0badf00d", d); end
    reg_read(3'd1, d, v);
    n_cmp++; if (d !== 32'h0000_0100) begin n_bad++; $display("FAIL single_drained got=%h exp=00000100", d); end
  endtask

  initial begin
    rst = 1'b1; int_valid = 1'b0; int_sop = 1'b0; int_eop = 1'b0;
    rtc_sec = '0; rtc_ns = '0; ptp_found = 1'b0; ptp_infor = '0;
    reg_addr = '0; reg_wr = 1'b0; reg_wdata = '0; reg_rd = 1'b0;
    test_reset();
    test_basic();
    test_non_ptp();
    test_overflow();
    test_back_to_back();
    test_config_reset();
    test_empty_sop_eop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
